core_biu_arb: RTL
=================

Name: core_biu_arb

Overview:
- Arbiter/sequencer sharing the single physical memory port between the instruction-fetch requester (read-only) and the EX-stage LSU requester (read/write).
- Sits between the IFU/LSU and the BIU memory interface.
- Exactly one outstanding transaction at a time; LSU has priority, with a starvation guard for IFU.
- Supports cancelling an in-flight fetch on a commit pipeline flush.

Parameters:
AW, 32, address width
DW, 32, data width (wmask width = DW/8)
STARVE_MAX, 4, consecutive LSU grants with IFU waiting before IFU is forced to win (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ifu_req_valid  in  1  fetch request
ifu_req_ready  out  1  fetch request accepted this cycle
ifu_req_addr  in  AW  fetch address
ifu_rsp_valid  out  1  fetch data valid, one-cycle pulse
ifu_rsp_data  out  DW  fetch data
ifu_flush  in  1  commit flush; kills pending/in-flight fetch
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_req_addr  in  AW  LSU address
lsu_req_wen  in  1  1 = store, 0 = load
lsu_req_wdata  in  DW  store data
lsu_req_wmask  in  DW/8  byte write mask
lsu_rsp_valid  out  1  load data / store ack, one-cycle pulse
lsu_rsp_data  out  DW  load data (don't-care for store)
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  AW  registered address
mem_req_wen  out  1  registered write enable (0 for IFU)
mem_req_wdata  out  DW  registered write data
mem_req_wmask  out  DW/8  registered mask (0 for IFU)
mem_rsp_valid  in  1  memory response
mem_rsp_data  in  DW  memory read data
arb_busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n = 0): state IDLE, owner = IFU, kill = 0, starve_cnt = 0; all mem_req_* registers 0; all outputs 0.
- States:
  - IDLE -> REQ on an accepted request.
  - REQ -> WAIT when mem_req_valid & mem_req_ready.
  - WAIT -> IDLE when mem_rsp_valid.
- Grant (combinational, IDLE only):
  - LSU wins if lsu_req_valid and not (ifu_req_valid & starve_cnt == STARVE_MAX).
  - Otherwise IFU wins if ifu_req_valid & ~ifu_flush.
  - Loser's and non-IDLE req_ready are 0.
  - ifu_req_valid with ifu_flush in IDLE: not granted.
- Accept cycle N:
  - Latch addr/wen/wdata/wmask/owner.
  - mem_req_valid = 1 from N+1, held with stable payload until mem_req_ready.
  - Minimum latency accept -> mem_req_valid is 1 cycle.
- mem_req_valid deasserts the cycle after handshake (registered). It is never asserted in IDLE or WAIT.
- mem_rsp_valid outside WAIT is ignored. Memory must return its response no earlier than the cycle after the request handshake.
- In WAIT, on mem_rsp_valid: owner's rsp_valid = 1 the same cycle (combinational pass-through), rsp_data = mem_rsp_data.
  - The other requester's rsp_valid stays 0.
  - Next cycle is IDLE; a new grant is possible in that cycle, so back-to-back transactions are spaced by 1 idle cycle minimum.
- Starvation counter:
  - On an LSU grant with ifu_req_valid = 1: increment, saturating at STARVE_MAX.
  - On an LSU grant with ifu_req_valid = 0: cleared to 0.
  - On an IFU grant: cleared to 0.
- Flush:
  - ifu_flush while owner = IFU in REQ or WAIT sets kill.
  - The transaction still completes on the memory side (request not withdrawn).
  - ifu_rsp_valid is suppressed for that response.
  - kill clears on entry to IDLE.
  - Flush during an LSU transaction has no effect on it.
  - Flush in the same cycle as mem_rsp_valid for an IFU transaction also suppresses ifu_rsp_valid.
- Stores: the memory responds with mem_rsp_valid as the write ack; this is forwarded as lsu_rsp_valid.
- Reset mid-transaction returns to IDLE immediately; no response is generated.

Test Plan:
1. IFU only, addr 0x8000_0000, mem_req_ready = 1, response 2 cycles later with data 0x0000_0013 -> mem_req_valid in cycle N+1, ifu_rsp_valid pulse with data 0x13, arb_busy low afterwards.
2. Simultaneous IFU and LSU load (0x8000_0100) in IDLE -> lsu_req_ready = 1, ifu_req_ready = 0; mem_req_addr = 0x8000_0100, wen = 0; lsu_rsp_valid only.
3. LSU store addr 0x8000_0200, wdata 0xDEADBEEF, wmask 0xF, mem_req_ready low for 3 cycles -> payload held stable for all 4 mem_req_valid cycles; lsu_rsp_valid on ack.
4. LSU and IFU both requesting continuously, STARVE_MAX = 4 -> grant sequence L, L, L, L, I, L, L, L, L, I.
5. IFU fetch in WAIT, ifu_flush pulsed one cycle before mem_rsp_valid -> no ifu_rsp_valid; state returns to IDLE; the next IFU request is serviced normally.
6. rst_n asserted during REQ with mem_req_valid = 1 -> mem_req_valid, arb_busy, and both req_ready outputs 0 immediately; a later response is ignored.

Source files
------------

// File: rtl/core_biu_arb.sv
`default_nettype none
// ============================================================================
// Module : core_biu_arb
// Desc   : Single-outstanding arbiter sharing the memory port between IFU and LSU.
// Rev    : 1.0
// ============================================================================
module core_biu_arb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [AW-1:0]     ifu_req_addr,
    output logic              ifu_rsp_valid,
    output logic [DW-1:0]     ifu_rsp_data,
    input  logic              ifu_flush,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [AW-1:0]     lsu_req_addr,
    input  logic              lsu_req_wen,
    input  logic [DW-1:0]     lsu_req_wdata,
    input  logic [DW/8-1:0]   lsu_req_wmask,
    output logic              lsu_rsp_valid,
    output logic [DW-1:0]     lsu_rsp_data,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [AW-1:0]     mem_req_addr,
    output logic              mem_req_wen,
    output logic [DW-1:0]     mem_req_wdata,
    output logic [DW/8-1:0]   mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DW-1:0]     mem_rsp_data,

    output logic              arb_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    state_t             r_state;
    logic               r_owner_lsu;
    logic               r_kill;
    logic [3:0]         r_starve_cnt;
    logic               r_mem_req_valid;
    logic [AW-1:0]      r_mem_req_addr;
    logic               r_mem_req_wen;
    logic [DW-1:0]      r_mem_req_wdata;
    logic [DW/8-1:0]    r_mem_req_wmask;

    logic w_idle;
    logic w_ifu_starved;
    logic w_lsu_grant;
    logic w_ifu_grant;
    logic w_rsp;

    assign w_idle        = (r_state == S_IDLE);
    assign w_ifu_starved = ifu_req_valid && (r_starve_cnt == C_STARVE_MAX);
    // rst_n gating keeps the ready outputs low while reset is held
    assign w_lsu_grant   = rst_n && w_idle && lsu_req_valid && !w_ifu_starved;
    assign w_ifu_grant   = rst_n && w_idle && !w_lsu_grant && ifu_req_valid && !ifu_flush;
    assign w_rsp         = (r_state == S_WAIT) && mem_rsp_valid;

    assign lsu_req_ready = w_lsu_grant;
    assign ifu_req_ready = w_ifu_grant;

    assign ifu_rsp_valid = w_rsp && !r_owner_lsu && !r_kill && !ifu_flush;
    assign lsu_rsp_valid = w_rsp && r_owner_lsu;
    assign ifu_rsp_data  = ifu_rsp_valid ? mem_rsp_data : '0;
    assign lsu_rsp_data  = lsu_rsp_valid ? mem_rsp_data : '0;

    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_addr  = r_mem_req_addr;
    assign mem_req_wen   = r_mem_req_wen;
    assign mem_req_wdata = r_mem_req_wdata;
    assign mem_req_wmask = r_mem_req_wmask;
    assign arb_busy      = !w_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_owner_lsu     <= 1'b0;
            r_kill          <= 1'b0;
            r_starve_cnt    <= 4'd0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_addr  <= '0;
            r_mem_req_wen   <= 1'b0;
            r_mem_req_wdata <= '0;
            r_mem_req_wmask <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_lsu_grant || w_ifu_grant) begin
                        r_state         <= S_REQ;
                        r_owner_lsu     <= w_lsu_grant;
                        r_mem_req_valid <= 1'b1;
                        r_mem_req_addr  <= w_lsu_grant ? lsu_req_addr : ifu_req_addr;
                        r_mem_req_wen   <= w_lsu_grant && lsu_req_wen;
                        r_mem_req_wdata <= w_lsu_grant ? lsu_req_wdata : '0;
                        r_mem_req_wmask <= w_lsu_grant ? lsu_req_wmask : '0;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_state         <= S_WAIT;
                        r_mem_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state         <= S_IDLE;
                    r_mem_req_valid <= 1'b0;
                end
            endcase

            // A killed fetch still completes on the memory side; only its response is dropped
            if (w_rsp) begin
                r_kill <= 1'b0;
            end else if (!w_idle && !r_owner_lsu && ifu_flush) begin
                r_kill <= 1'b1;
            end

            if (w_lsu_grant) begin
                if (!ifu_req_valid) begin
                    r_starve_cnt <= 4'd0;
                end else if (r_starve_cnt != C_STARVE_MAX) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end else if (w_ifu_grant) begin
                r_starve_cnt <= 4'd0;
            end
        end
    end

endmodule
`default_nettype wire
